ssio_ddr_in_deser: RTL and testbench
====================================

SSIO_DDR_IN_DESER -- requirements
Module: ssio_ddr_in_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 1: number of DDR data lanes.
REQ-002 SHALL have parameter RATIO, default 4, legal 2..8: input cycles per output word; lane word width W = 2*RATIO.
REQ-003 SHALL have parameter TRAIN_PATTERN, default 8'hF0, width W: per-lane training word.
REQ-004 SHALL have parameter LOCK_COUNT, default 4, legal 1..255: consecutive matching words required to lock.
REQ-005 SHALL have one clock and a synchronous active-high reset: clk input 1, rising-edge clock for all logic; rst input 1, synchronous active-high reset.
REQ-006 SHALL have in_q1 input WIDTH: rising-edge DDR sample per lane, earlier in time than in_q2.
REQ-007 SHALL have in_q2 input WIDTH: falling-edge DDR sample per lane.
REQ-008 SHALL have in_valid input 1: qualifies in_q1/in_q2 this cycle.
REQ-009 SHALL have align_enable input 1: level request to run alignment.
REQ-010 SHALL have out_data output WIDTH*W: lane n occupies bits [n*W +: W]; bit W-1 of each lane is the earliest received bit.
REQ-011 SHALL have out_valid output 1: single-cycle strobe per assembled word.
REQ-012 SHALL have locked output 1, align_fail output 1, bit_offset output clog2(W), and err_count output 16.

Function
REQ-013 Per lane, history shift register of 2*W bits; on in_valid, hist <= {hist[2W-3:0], in_q1, in_q2}; no shift when in_valid=0.
REQ-014 Lane word = hist[bit_offset +: W]; offset 0 = most recent W bits; each offset increment delays the word by one bit.
REQ-015 Phase counter 0..RATIO-1 advances on in_valid and wraps; the beat with phase=RATIO-1 completes a word.
REQ-016 out_valid SHALL assert exactly one cycle after the completing beat, with out_data registered; out_data holds between strobes; no backpressure.
REQ-017 match = every lane word equals TRAIN_PATTERN on the same strobe.
REQ-018 FSM states IDLE, SEARCH, SLIP_WAIT, LOCKED; evaluation occurs only on word-completion cycles.
REQ-019 IDLE: words emitted at current bit_offset; align_enable=1 -> SEARCH with match_cnt=0.
REQ-020 SEARCH: match -> match_cnt+1; match_cnt reaching LOCK_COUNT -> LOCKED, locked=1. Mismatch -> bit_offset=(bit_offset+1) mod W, match_cnt=0, slip counter+1, -> SLIP_WAIT.
REQ-021 SLIP_WAIT: discard 2 words from comparison (still output), then -> SEARCH.
REQ-022 After W consecutive slips without lock, align_fail SHALL set (sticky until rst or align_enable falling) and search SHALL continue; slip counter then restarts at 0.
REQ-023 LOCKED: bit_offset frozen; each mismatching word increments err_count, saturating at 16'hFFFF.
REQ-024 align_enable=0 in any state -> IDLE next cycle, locked=0, align_fail=0, bit_offset retained, err_count retained.
REQ-025 align_enable re-asserted -> SEARCH from retained bit_offset; err_count clears on IDLE->SEARCH.
REQ-026 A slip SHALL not alter phase counter or drop/duplicate out_valid strobes.

Reset
REQ-027 rst=1 at a clock edge SHALL set hist=0, phase=0, bit_offset=0, state=IDLE, match_cnt=0, slip counter=0, out_data=0, out_valid=0, locked=0, align_fail=0, err_count=0.
REQ-028 rst SHALL override all inputs, including mid-word and mid-alignment; first word after release completes on the RATIO-th valid beat.

Verification
REQ-029 WIDTH=2, RATIO=4, offset 0, align_enable=0, stream repeating 8'hA5 both lanes, in_valid=1 continuously -> out_valid every 4th cycle, out_data=16'hA5A5 after history fills.
REQ-030 Stream 8'hF0 delayed 3 bits, align_enable=1 -> 3 slips, bit_offset=3, locked=1 after 4 matches, align_fail=0.
REQ-031 Locked, inject one corrupted word on lane 1 -> err_count=1, locked stays 1, bit_offset stays 3.
REQ-032 Constant 8'h00 stream, align_enable=1 -> align_fail=1 after 8 slips, bit_offset back to 0, locked=0.
REQ-033 in_valid toggled 1/0 every cycle -> out_valid every 8 cycles, data identical to continuous case.
REQ-034 rst asserted during SLIP_WAIT -> all outputs 0 next cycle, state IDLE; relock after release succeeds per REQ-030.

Source files
------------

// File: rtl/ssio_ddr_in_deser.sv
// DDR input deserializer with per-lane history, bit-slip word alignment
// and lock / error tracking. All logic runs on the rising edge of clk.
module ssio_ddr_in_deser #(
    parameter int                   WIDTH         = 1,
    parameter int                   RATIO         = 4,
    parameter logic [2*RATIO-1:0]   TRAIN_PATTERN = (2*RATIO)'(8'hF0),
    parameter int                   LOCK_COUNT    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0]               in_q1,
    input  logic [WIDTH-1:0]               in_q2,
    input  logic                           in_valid,
    input  logic                           align_enable,
    output logic [WIDTH*2*RATIO-1:0]       out_data,
    output logic                           out_valid,
    output logic                           locked,
    output logic                           align_fail,
    output logic [$clog2(2*RATIO)-1:0]     bit_offset,
    output logic [15:0]                    err_count
);

    localparam int W  = 2 * RATIO;
    localparam int OW = $clog2(W);
    localparam int PW = $clog2(RATIO);

    localparam logic [PW-1:0] PH_LAST   = PW'(RATIO - 1);
    localparam logic [OW-1:0] OFF_LAST  = OW'(W - 1);
    localparam logic [7:0]    LOCK_LAST = 8'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEARCH    = 2'd1,
        ST_SLIP_WAIT = 2'd2,
        ST_LOCKED    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PW-1:0]       r_phase;
    logic [OW-1:0]       r_bit_offset;
    logic [OW:0]         w_sel;
    logic [7:0]          r_match_cnt;
    logic [OW-1:0]       r_slip_cnt;
    logic                r_wait_cnt;
    logic                r_align_fail;
    logic [15:0]         r_err_count;
    logic [W*WIDTH-1:0]  r_out_data;
    logic                r_out_valid;

    logic [W*WIDTH-1:0]  w_word;
    logic [WIDTH-1:0]    w_lane_match;
    logic                w_match;
    logic                w_word_done;
    logic [OW-1:0]       w_offset_inc;

    logic                w_start;
    logic                w_slip;
    logic                w_match_step;
    logic                w_wait_step;
    logic                w_err_step;

    assign w_word_done  = in_valid && (r_phase == PH_LAST);
    assign w_sel        = {1'b0, r_bit_offset};
    assign w_offset_inc = (r_bit_offset == OFF_LAST) ? '0 : r_bit_offset + OW'(1);
    assign w_match      = &w_lane_match;

    // Per lane: the register keeps the older 2W-2 bits; together with the
    // pair arriving this beat that forms the full 2W-bit history, so the
    // word leaving on a completing beat already contains that beat's bits.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        logic [2*W-3:0] r_hist;
        logic [2*W-1:0] w_hist_next;

        assign w_hist_next           = {r_hist, in_q1[gi], in_q2[gi]};
        assign w_word[gi*W +: W]     = w_hist_next[w_sel +: W];
        assign w_lane_match[gi]      = (w_hist_next[w_sel +: W] == TRAIN_PATTERN);

        // Shift the lane history by one DDR pair on every valid beat
        always_ff @(posedge clk) begin
            if (rst) begin
                r_hist <= '0;
            end else if (in_valid) begin
                r_hist <= w_hist_next[2*W-3:0];
            end
        end
    end

    // Beat phase within the current word; slips never touch it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
        end else if (in_valid) begin
            r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PW'(1);
        end
    end

    // Register the assembled word and strobe it for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_word_done;
            if (w_word_done) begin
                r_out_data <= w_word;
            end
        end
    end

    // Alignment FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Alignment FSM next-state: words are judged only when one completes
    always_comb begin
        w_state_next = r_state;
        if (!align_enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      w_state_next = ST_SEARCH;
                ST_SEARCH: begin
                    if (w_word_done) begin
                        if (!w_match) begin
                            w_state_next = ST_SLIP_WAIT;
                        end else if (r_match_cnt == LOCK_LAST) begin
                            w_state_next = ST_LOCKED;
                        end
                    end
                end
                ST_SLIP_WAIT: begin
                    if (w_word_done && r_wait_cnt) begin
                        w_state_next = ST_SEARCH;
                    end
                end
                ST_LOCKED:    w_state_next = ST_LOCKED;
                default:      w_state_next = ST_IDLE;
            endcase
        end
    end

    // Alignment FSM outputs: lock flag plus datapath step strobes
    always_comb begin
        locked       = (r_state == ST_LOCKED);
        w_start      = 1'b0;
        w_slip       = 1'b0;
        w_match_step = 1'b0;
        w_wait_step  = 1'b0;
        w_err_step   = 1'b0;
        if (align_enable) begin
            case (r_state)
                ST_IDLE:      w_start      = 1'b1;
                ST_SEARCH: begin
                    w_slip       = w_word_done && !w_match;
                    w_match_step = w_word_done && w_match;
                end
                ST_SLIP_WAIT: w_wait_step  = w_word_done;
                ST_LOCKED:    w_err_step   = w_word_done && !w_match;
                default:      w_start      = 1'b0;
            endcase
        end
    end

    // Alignment bookkeeping: offset, match/slip/wait counters, fail, errors
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_offset <= '0;
            r_match_cnt  <= '0;
            r_slip_cnt   <= '0;
            r_wait_cnt   <= 1'b0;
            r_align_fail <= 1'b0;
            r_err_count  <= '0;
        end else begin
            if (w_start) begin
                r_match_cnt <= '0;
                r_slip_cnt  <= '0;
                r_wait_cnt  <= 1'b0;
                r_err_count <= '0;
            end
            if (w_slip) begin
                r_bit_offset <= w_offset_inc;
                r_match_cnt  <= '0;
                r_wait_cnt   <= 1'b0;
                // A full sweep of offsets without lock flags failure and
                // starts the sweep count again while searching continues.
                if (r_slip_cnt == OFF_LAST) begin
                    r_slip_cnt   <= '0;
                    r_align_fail <= 1'b1;
                end else begin
                    r_slip_cnt <= r_slip_cnt + OW'(1);
                end
            end
            if (w_match_step) begin
                r_match_cnt <= r_match_cnt + 8'd1;
                if (r_match_cnt == LOCK_LAST) begin
                    r_slip_cnt <= '0;
                end
            end
            if (w_wait_step) begin
                r_wait_cnt <= ~r_wait_cnt;
            end
            if (w_err_step && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
            if (!align_enable) begin
                r_align_fail <= 1'b0;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign align_fail = r_align_fail;
    assign bit_offset = r_bit_offset;
    assign err_count  = r_err_count;

endmodule

// File: tb/tb_ssio_ddr_in_deser.sv
// Bench for ssio_ddr_in_deser: a bit-stream model predicts every output on
// every cycle; literal expectations pin the model at key points.
module tb_ssio_ddr_in_deser;

    localparam int WIDTH = 2;
    localparam int RATIO = 4;
    localparam int W     = 8;
    localparam int LOCK  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  in_q1 = '0;
    logic [1:0]  in_q2 = '0;
    logic        in_valid = 1'b0;
    logic        align_enable = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        locked;
    logic        align_fail;
    logic [2:0]  bit_offset;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    ssio_ddr_in_deser #(
        .WIDTH(WIDTH), .RATIO(RATIO), .TRAIN_PATTERN(8'hF0), .LOCK_COUNT(LOCK)
    ) dut (
        .clk(clk), .rst(rst), .in_q1(in_q1), .in_q2(in_q2), .in_valid(in_valid),
        .align_enable(align_enable), .out_data(out_data), .out_valid(out_valid),
        .locked(locked), .align_fail(align_fail), .bit_offset(bit_offset),
        .err_count(err_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [1:0]  strm[$];      // received bits in time order; entry bit l = lane l
    int        m_beats, m_mode, m_off, m_mcnt, m_slips, m_wait, m_err;
    bit        m_fail;
    bit        exp_valid;
    bit [15:0] exp_data;
    bit        chk_on = 1'b0;

    function automatic bit [7:0] m_word(input int lane);
        bit [7:0] w;
        bit [1:0] e;
        int       n;
        int       idx;
        w = '0;
        n = strm.size();
        for (int k = 0; k < W; k++) begin
            idx = n - 1 - m_off - k;
            if (idx >= 0) begin
                e    = strm[idx];
                w[k] = e[lane];
            end
        end
        return w;
    endfunction

    // mode: 0 idle, 1 search, 2 slip wait, 3 locked
    task automatic model_step(input bit r, input bit [1:0] q1, input bit [1:0] q2,
                              input bit v, input bit en);
        bit       done;
        bit       match;
        bit [7:0] wd;
        if (r) begin
            strm.delete();
            m_beats = 0; m_mode = 0; m_off = 0; m_mcnt = 0; m_slips = 0;
            m_wait = 0; m_err = 0; m_fail = 0; exp_valid = 0; exp_data = '0;
            return;
        end
        done      = 1'b0;
        match     = 1'b1;
        exp_valid = 1'b0;
        if (v) begin
            strm.push_back(q1);
            strm.push_back(q2);
            m_beats++;
            done = ((m_beats % RATIO) == 0);
        end
        if (done) begin
            for (int l = 0; l < WIDTH; l++) begin
                wd = m_word(l);
                exp_data[l*W +: W] = wd;
                if (wd != 8'hF0) match = 1'b0;
            end
            exp_valid = 1'b1;
        end
        if (!en) begin
            m_mode = 0;
            m_fail = 0;
        end else begin
            case (m_mode)
                0: begin m_mode = 1; m_mcnt = 0; m_slips = 0; m_err = 0; end
                1: if (done) begin
                    if (match) begin
                        m_mcnt++;
                        if (m_mcnt == LOCK) begin m_mode = 3; m_slips = 0; end
                    end else begin
                        m_off  = (m_off + 1) % W;
                        m_mcnt = 0;
                        m_slips++;
                        if (m_slips == W) begin m_fail = 1; m_slips = 0; end
                        m_mode = 2;
                        m_wait = 0;
                    end
                end
                2: if (done) begin
                    m_wait++;
                    if (m_wait == 2) m_mode = 1;
                end
                default: if (done && !match && m_err < 65535) m_err++;
            endcase
        end
    endtask

    // Compare every cycle, half a period away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("out_valid",  32'(out_valid),  32'(exp_valid));
            check("out_data",   32'(out_data),   32'(exp_data));
            check("locked",     32'(locked),     32'(m_mode == 3));
            check("align_fail", 32'(align_fail), 32'(m_fail));
            check("bit_offset", 32'(bit_offset), 32'(m_off));
            check("err_count",  32'(err_count),  32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] g_pat = 8'hA5;
    int         g_rot = 0;
    int         g_idx = 0;
    int         g_flip = -1;
    int         n_strobes = 0;

    function automatic bit src(input int lane, input int k);
        bit b;
        b = g_pat[7 - ((k + g_rot) % 8)];
        if (lane == 1 && k == g_flip) b = ~b;
        return b;
    endfunction

    task automatic cyc(input bit v, input bit en, input bit r);
        rst          = r;
        in_valid     = v;
        align_enable = en;
        if (v) begin
            for (int l = 0; l < WIDTH; l++) begin
                in_q1[l] = src(l, g_idx);
                in_q2[l] = src(l, g_idx + 1);
            end
            g_idx += 2;
        end else begin
            in_q1 = 2'($urandom);
            in_q2 = 2'($urandom);
        end
        @(posedge clk);
        model_step(r, in_q1, in_q2, v, en);
        chk_on = 1'b1;
        #1;
        if (out_valid === 1'b1) n_strobes++;
        $display("cyc t=%0t rst=%0b v=%0b en=%0b q1=%b q2=%b | ov=%0b od=%h lk=%0b af=%0b off=%0d err=%0d",
                 $time, r, v, en, in_q1, in_q2, out_valid, out_data, locked, align_fail,
                 bit_offset, err_count);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b1);
        g_idx = 0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);

        // Continuous A5 stream, alignment off
        g_pat = 8'hA5; g_rot = 0; g_flip = -1; n_strobes = 0;
        repeat (16) cyc(1'b1, 1'b0, 1'b0);
        check("a5_strobes", 32'(n_strobes), 32'd4);
        check("a5_data", 32'(out_data), 32'hA5A5);

        // in_valid toggling: strobe every 8 cycles, same data
        do_reset();
        n_strobes = 0;
        repeat (16) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
        check("tog_strobes", 32'(n_strobes), 32'd4);
        check("tog_data", 32'(out_data), 32'hA5A5);

        // F0 stream needing offset 3: 3 slips then 4 matches
        do_reset();
        g_pat = 8'hF0; g_rot = 3;
        repeat (52) cyc(1'b1, 1'b1, 1'b0);
        check("lock_locked", 32'(locked), 32'h1);
        check("lock_offset", 32'(bit_offset), 32'd3);
        check("lock_fail", 32'(align_fail), 32'h0);
        check("lock_data", 32'(out_data), 32'hF0F0);

        // One corrupted bit on lane 1 while locked
        g_flip = g_idx + 5;
        repeat (16) cyc(1'b1, 1'b1, 1'b0);
        g_flip = -1;
        check("err_count", 32'(err_count), 32'd1);
        check("err_locked", 32'(locked), 32'h1);
        check("err_offset", 32'(bit_offset), 32'd3);

        // Drop enable: idle, offset and errors retained; re-enable clears errors
        cyc(1'b1, 1'b0, 1'b0);
        check("idle_locked", 32'(locked), 32'h0);
        check("idle_err", 32'(err_count), 32'd1);
        check("idle_offset", 32'(bit_offset), 32'd3);
        cyc(1'b1, 1'b1, 1'b0);
        check("reen_err", 32'(err_count), 32'd0);
        repeat (16) cyc(1'b1, 1'b1, 1'b0);
        check("relock_locked", 32'(locked), 32'h1);

        // Constant zero stream: fail after 8 slips, offset wraps to 0
        do_reset();
        g_pat = 8'h00; g_rot = 0;
        repeat (84) cyc(1'b1, 1'b1, 1'b0);
        check("z7_offset", 32'(bit_offset), 32'd7);
        check("z7_fail", 32'(align_fail), 32'h0);
        repeat (8) cyc(1'b1, 1'b1, 1'b0);
        check("z8_offset", 32'(bit_offset), 32'd0);
        check("z8_fail", 32'(align_fail), 32'h1);
        check("z8_locked", 32'(locked), 32'h0);
        cyc(1'b1, 1'b0, 1'b0);
        check("zdis_fail", 32'(align_fail), 32'h0);

        // Reset during slip wait, then relock
        do_reset();
        g_pat = 8'hF0; g_rot = 3;
        repeat (6) cyc(1'b1, 1'b1, 1'b0);
        check("sw_offset", 32'(bit_offset), 32'd1);
        cyc(1'b1, 1'b1, 1'b1);
        g_idx = 0;
        check("sw_rst_data", 32'(out_data), 32'h0);
        check("sw_rst_valid", 32'(out_valid), 32'h0);
        check("sw_rst_offset", 32'(bit_offset), 32'd0);
        check("sw_rst_locked", 32'(locked), 32'h0);
        repeat (52) cyc(1'b1, 1'b1, 1'b0);
        check("sw_relock", 32'(locked), 32'h1);
        check("sw_reoffset", 32'(bit_offset), 32'd3);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
